// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_pkg
// Description : Shared defaults, register-address type and zero-register
//               address for the regfile_sb register file.
//               Optional feature macro: REGFILE_BYPASS_EN (used in regfile_sb).
// Revision    : 1.0 - initial release
// ============================================================================
package regfile_pkg;

    // Default geometry of the register file.
    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 3;

    // Number of architectural registers at the default address width.
    localparam int NREG = 2 ** ADDR_W_DEF;

    // Register address at the default address width.
    typedef logic [ADDR_W_DEF-1:0] reg_addr_t;

    // Address of the optionally hardwired-zero register.
    localparam reg_addr_t ZERO_ADDR = '0;

endpackage : regfile_pkg
`default_nettype wire

// File: rtl/regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : regfile_scoreboard
// Description : Per-register busy bits. Issue reserves a destination, the
//               matching writeback releases it; a same-edge reserve wins over
//               the release so the newest producer stays tracked.
//               Exposes two busy lookups and the OR of all busy bits.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              i_rst_n,
    input  logic              i_release_en,
    input  logic [ADDR_W-1:0] i_release_reg,
    input  logic              i_reserve_en,
    input  logic [ADDR_W-1:0] i_reserve_reg,
    input  logic [ADDR_W-1:0] i_rd_addr1,
    input  logic [ADDR_W-1:0] i_rd_addr2,
    output logic              o_busy1,
    output logic              o_busy2,
    output logic              o_any_busy
);

    localparam int NUM_REGS = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] C_ZERO_ADDR = ADDR_W'(ZERO_ADDR);

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;

    // Next busy vector: release first, then reserve so a same-edge reserve wins.
    always_comb begin
        busy_d = busy_q;
        if (i_release_en) begin
            busy_d[i_release_reg] = 1'b0;
        end
        if (i_reserve_en) begin
            busy_d[i_reserve_reg] = 1'b1;
        end
        if (ZERO_REG != 0) begin
            busy_d[C_ZERO_ADDR] = 1'b0;
        end
    end

    // Busy flops, cleared asynchronously so in-flight reservations vanish at reset.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // Lookups and drain indicator reflect stored state only.
    always_comb begin
        o_busy1    = busy_q[i_rd_addr1];
        o_busy2    = busy_q[i_rd_addr2];
        o_any_busy = |busy_q;
    end

endmodule : regfile_scoreboard
`default_nettype wire

// File: rtl/regfile_sb.sv
`default_nettype none
// ============================================================================
// Module      : regfile_sb
// Description : Parametrised register file with two combinational read ports,
//               one synchronous write port and a busy scoreboard for RAW
//               hazard detection. Register 0 can be hardwired to zero.
//               Optional macro REGFILE_BYPASS_EN forwards the write port onto
//               matching read ports in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] readreg1,
    input  logic [ADDR_W-1:0] readreg2,
    output logic [DATA_W-1:0] readData1,
    output logic [DATA_W-1:0] readData2,
    output logic              busy1,
    output logic              busy2,
    input  logic              writeEnable,
    input  logic [ADDR_W-1:0] writeReg,
    input  logic [DATA_W-1:0] writeData,
    input  logic              reserveEnable,
    input  logic [ADDR_W-1:0] reserveReg,
    output logic              anyBusy
);

    localparam int NUM_REGS = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] C_ZERO_ADDR = ADDR_W'(ZERO_ADDR);

    logic [DATA_W-1:0] mem_q [NUM_REGS];
    logic [DATA_W-1:0] mem_d [NUM_REGS];

    logic              w_wr_ok;
    logic              w_rsv_ok;
    logic              w_rd1_zero;
    logic              w_rd2_zero;
    logic [DATA_W-1:0] w_stored1;
    logic [DATA_W-1:0] w_stored2;
    logic              w_sb_busy1;
    logic              w_sb_busy2;

    // Qualify writes and reserves: the hardwired-zero register drops both.
    always_comb begin
        w_wr_ok  = writeEnable;
        w_rsv_ok = reserveEnable;
        if ((ZERO_REG != 0) && (writeReg == C_ZERO_ADDR)) begin
            w_wr_ok = 1'b0;
        end
        if ((ZERO_REG != 0) && (reserveReg == C_ZERO_ADDR)) begin
            w_rsv_ok = 1'b0;
        end
    end

    // Next data array: only the addressed register changes on a write.
    always_comb begin
        mem_d = mem_q;
        if (w_wr_ok) begin
            mem_d[writeReg] = writeData;
        end
    end

    // Data flops, cleared asynchronously so pending writes are discarded at reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    // Stored read values with the zero register forced to zero.
    always_comb begin
        w_rd1_zero = (ZERO_REG != 0) && (readreg1 == C_ZERO_ADDR);
        w_rd2_zero = (ZERO_REG != 0) && (readreg2 == C_ZERO_ADDR);
        w_stored1  = w_rd1_zero ? '0 : mem_q[readreg1];
        w_stored2  = w_rd2_zero ? '0 : mem_q[readreg2];
    end

    regfile_scoreboard #(
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk           (clk),
        .i_rst_n       (reset),
        .i_release_en  (w_wr_ok),
        .i_release_reg (writeReg),
        .i_reserve_en  (w_rsv_ok),
        .i_reserve_reg (reserveReg),
        .i_rd_addr1    (readreg1),
        .i_rd_addr2    (readreg2),
        .o_busy1       (w_sb_busy1),
        .o_busy2       (w_sb_busy2),
        .o_any_busy    (anyBusy)
    );

`ifdef REGFILE_BYPASS_EN
    logic w_hit1;
    logic w_hit2;

    // Forward the in-flight write onto matching read ports; a forwarded
    // register is about to be released, so its busy reads 0. Reset masks
    // the forward so outputs stay zero while held in reset.
    always_comb begin
        w_hit1    = reset && w_wr_ok && (writeReg == readreg1);
        w_hit2    = reset && w_wr_ok && (writeReg == readreg2);
        readData1 = w_hit1 ? writeData : w_stored1;
        readData2 = w_hit2 ? writeData : w_stored2;
        busy1     = w_sb_busy1 & ~w_hit1;
        busy2     = w_sb_busy2 & ~w_hit2;
    end
`else
    // Read ports show stored state only; writes appear after the edge.
    always_comb begin
        readData1 = w_stored1;
        readData2 = w_stored2;
        busy1     = w_sb_busy1;
        busy2     = w_sb_busy2;
    end
`endif

endmodule : regfile_sb
`default_nettype wire

// File: tb/tb_regfile_sb.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_sb
// Description : Self-checking bench for regfile_sb: directed table, hand
//               sequences for reset/latency/async reset, and randomized
//               traffic compared against an array-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_sb;
    import regfile_pkg::*;

    logic        clk;
    logic        reset;
    reg_addr_t   readreg1, readreg2, writeReg, reserveReg;
    logic [15:0] readData1, readData2, writeData;
    logic        busy1, busy2, writeEnable, reserveEnable, anyBusy;

    int errors = 0;
    int checks = 0;

    regfile_sb #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(1)) dut (
        .clk           (clk),
        .reset         (reset),
        .readreg1      (readreg1),
        .readreg2      (readreg2),
        .readData1     (readData1),
        .readData2     (readData2),
        .busy1         (busy1),
        .busy2         (busy2),
        .writeEnable   (writeEnable),
        .writeReg      (writeReg),
        .writeData     (writeData),
        .reserveEnable (reserveEnable),
        .reserveReg    (reserveReg),
        .anyBusy       (anyBusy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Directed vector: inputs for one edge, reads checked after it.
    typedef struct packed {
        logic        we;
        logic [2:0]  wr;
        logic [15:0] wd;
        logic        re;
        logic [2:0]  rr;
        logic [2:0]  a1;
        logic [2:0]  a2;
        logic [15:0] e1;
        logic [15:0] e2;
        logic        eb1;
        logic        eb2;
        logic        eany;
    } vec_t;

    vec_t vt [11];

    // Reference model state.
    logic [15:0] mem_m  [NREG];
    logic        busy_m [NREG];

    function automatic logic [15:0] exp_rd(input int a);
        if (a == 0) return 16'h0000;
`ifdef REGFILE_BYPASS_EN
        if (writeEnable && (int'(writeReg) == a)) return writeData;
`endif
        return mem_m[a];
    endfunction

    function automatic logic exp_busy(input int a);
        if (a == 0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
        if (writeEnable && (int'(writeReg) == a)) return 1'b0;
`endif
        return busy_m[a];
    endfunction

    function automatic logic exp_any();
        logic r = 1'b0;
        for (int i = 0; i < NREG; i++) r |= busy_m[i];
        return r;
    endfunction

    initial begin
        reset = 1'b0;
        writeEnable = 1'b0; writeReg = '0; writeData = '0;
        reserveEnable = 1'b0; reserveReg = '0;
        readreg1 = '0; readreg2 = '0;

        //                we   wr    wd        re   rr    a1    a2    e1        e2        b1   b2   any
        vt[0]  = '{1'b1, 3'd3, 16'hBEEF, 1'b0, 3'd0, 3'd3, 3'd1, 16'hBEEF, 16'h0000, 1'b0, 1'b0, 1'b0};
        vt[1]  = '{1'b0, 3'd0, 16'h0000, 1'b1, 3'd2, 3'd3, 3'd2, 16'hBEEF, 16'h0000, 1'b0, 1'b1, 1'b1};
        vt[2]  = '{1'b1, 3'd0, 16'hFFFF, 1'b1, 3'd0, 3'd0, 3'd0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1};
        vt[3]  = '{1'b1, 3'd2, 16'h00AA, 1'b0, 3'd0, 3'd3, 3'd2, 16'hBEEF, 16'h00AA, 1'b0, 1'b0, 1'b0};
        vt[4]  = '{1'b0, 3'd0, 16'h0000, 1'b1, 3'd4, 3'd4, 3'd2, 16'h0000, 16'h00AA, 1'b1, 1'b0, 1'b1};
        vt[5]  = '{1'b1, 3'd4, 16'h0F0F, 1'b1, 3'd4, 3'd4, 3'd4, 16'h0F0F, 16'h0F0F, 1'b1, 1'b1, 1'b1};
        vt[6]  = '{1'b1, 3'd5, 16'h1234, 1'b1, 3'd6, 3'd5, 3'd6, 16'h1234, 16'h0000, 1'b0, 1'b1, 1'b1};
        vt[7]  = '{1'b0, 3'd0, 16'h0000, 1'b1, 3'd6, 3'd5, 3'd6, 16'h1234, 16'h0000, 1'b0, 1'b1, 1'b1};
        vt[8]  = '{1'b1, 3'd7, 16'h5555, 1'b0, 3'd0, 3'd7, 3'd7, 16'h5555, 16'h5555, 1'b0, 1'b0, 1'b1};
        vt[9]  = '{1'b1, 3'd4, 16'h1111, 1'b0, 3'd0, 3'd4, 3'd6, 16'h1111, 16'h0000, 1'b0, 1'b1, 1'b1};
        vt[10] = '{1'b1, 3'd6, 16'h2222, 1'b0, 3'd0, 3'd4, 3'd6, 16'h1111, 16'h2222, 1'b0, 1'b0, 1'b0};

        // ---- Reset held with a write pending: nothing may land ----
        writeEnable = 1'b1; writeReg = 3'd3; writeData = 16'hBEEF; readreg1 = 3'd3;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_hold_rd", readData1, 16'h0000);
        chk("rst_hold_any", 16'(anyBusy), 16'h0000);
        @(negedge clk);
        writeEnable = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        chk("rst_rel_rd", readData1, 16'h0000);
        chk("rst_rel_any", 16'(anyBusy), 16'h0000);

        // ---- Directed table ----
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            writeEnable = vt[i].we; writeReg = vt[i].wr; writeData = vt[i].wd;
            reserveEnable = vt[i].re; reserveReg = vt[i].rr;
            readreg1 = vt[i].a1; readreg2 = vt[i].a2;
            @(posedge clk); #1;
            writeEnable = 1'b0; reserveEnable = 1'b0;
            #1;
            chk($sformatf("vec%0d_rd1", i), readData1, vt[i].e1);
            chk($sformatf("vec%0d_rd2", i), readData2, vt[i].e2);
            chk($sformatf("vec%0d_b1", i), 16'(busy1), 16'(vt[i].eb1));
            chk($sformatf("vec%0d_b2", i), 16'(busy2), 16'(vt[i].eb2));
            chk($sformatf("vec%0d_any", i), 16'(anyBusy), 16'(vt[i].eany));
        end

        // ---- Write latency on r5 (currently 1234) ----
        @(negedge clk);
        writeEnable = 1'b1; writeReg = 3'd5; writeData = 16'hABCD; readreg1 = 3'd5;
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("lat_pre", readData1, 16'hABCD);
`else
        chk("lat_pre", readData1, 16'h1234);
`endif
        @(posedge clk); #1;
        chk("lat_post", readData1, 16'hABCD);
        writeEnable = 1'b0;

        // ---- Async reset mid-flight with r1 and r6 busy ----
        @(negedge clk);
        reserveEnable = 1'b1; reserveReg = 3'd1;
        @(negedge clk);
        reserveReg = 3'd6;
        @(negedge clk);
        reserveEnable = 1'b0; readreg1 = 3'd1; readreg2 = 3'd6;
        #1;
        chk("ar_pre_b1", 16'(busy1), 16'h0001);
        chk("ar_pre_b2", 16'(busy2), 16'h0001);
        #1;
        reset = 1'b0;
        #1;
        chk("ar_b1", 16'(busy1), 16'h0000);
        chk("ar_b2", 16'(busy2), 16'h0000);
        chk("ar_any", 16'(anyBusy), 16'h0000);
        readreg1 = 3'd5; readreg2 = 3'd7;
        #1;
        chk("ar_rd5", readData1, 16'h0000);
        chk("ar_rd7", readData2, 16'h0000);
        @(negedge clk);
        reset = 1'b1;

        // ---- Randomized traffic against the reference model ----
        for (int i = 0; i < NREG; i++) begin
            mem_m[i] = 16'h0000;
            busy_m[i] = 1'b0;
        end
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            writeEnable   = ($urandom_range(0, 99) < 45);
            writeReg      = reg_addr_t'($urandom_range(0, NREG - 1));
            writeData     = 16'($urandom);
            reserveEnable = ($urandom_range(0, 99) < 45);
            reserveReg    = reg_addr_t'($urandom_range(0, NREG - 1));
            readreg1      = reg_addr_t'($urandom_range(0, NREG - 1));
            readreg2      = ($urandom_range(0, 3) == 0) ? writeReg
                                                        : reg_addr_t'($urandom_range(0, NREG - 1));
            #1;
            chk("rnd_rd1", readData1, exp_rd(int'(readreg1)));
            chk("rnd_rd2", readData2, exp_rd(int'(readreg2)));
            chk("rnd_b1", 16'(busy1), 16'(exp_busy(int'(readreg1))));
            chk("rnd_b2", 16'(busy2), 16'(exp_busy(int'(readreg2))));
            chk("rnd_any", 16'(anyBusy), 16'(exp_any()));
            @(posedge clk);
            // Architectural rules: register 0 ignores everything; write
            // releases, and a same-edge reserve leaves the register busy.
            if (writeEnable && writeReg != 3'd0) begin
                mem_m[writeReg]  = writeData;
                busy_m[writeReg] = 1'b0;
            end
            if (reserveEnable && reserveReg != 3'd0) begin
                busy_m[reserveReg] = 1'b1;
            end
        end
        @(negedge clk);
        writeEnable = 1'b0; reserveEnable = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_regfile_sb
`default_nettype wire

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised general-purpose register file for the 16-bit RISC core.
- Provides two combinational read ports, one synchronous write port and a per-register busy scoreboard.
- Decode uses the scoreboard to detect RAW hazards against in-flight writes.
- Sits between decode (read/reserve) and writeback (write/release).
- Successor to the fixed 4x32 file: generalised in width and depth, with hardwired-zero register and hazard tracking added.

Parameters:
- DATA_W, 16, register width in bits.
- ADDR_W, 3, register address width; depth NREG = 2**ADDR_W.
- ZERO_REG, 1, when 1 register 0 reads as zero, ignores writes and is never busy.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- readreg1  input  ADDR_W  read port 1 address.
- readreg2  input  ADDR_W  read port 2 address.
- readData1  output  DATA_W  read port 1 data, combinational.
- readData2  output  DATA_W  read port 2 data, combinational.
- busy1  output  1  scoreboard bit of readreg1, combinational.
- busy2  output  1  scoreboard bit of readreg2, combinational.
- writeEnable  input  1  write strobe.
- writeReg  input  ADDR_W  write address.
- writeData  input  DATA_W  write data.
- reserveEnable  input  1  mark destination busy (issue).
- reserveReg  input  ADDR_W  destination being reserved.
- anyBusy  output  1  OR of all busy bits (pipeline drain indicator).

Behaviour:
- Reset (reset=0, asynchronous):
  - all NREG data registers clear to 0; all busy bits clear to 0.
  - Consequently readData1/2, busy1/2 and anyBusy read 0 while in reset.
  - Reset asserted mid-operation discards pending writes and reservations immediately.
- Write:
  - at the rising edge with writeEnable=1, reg[writeReg] <= writeData.
  - Visible on read ports the cycle after the edge (1-cycle write latency), unless BYPASS_EN is defined.
  - A write also clears busy[writeReg] (release).
- Reserve: at the rising edge with reserveEnable=1, busy[reserveReg] <= 1.
- Simultaneous write and reserve:
  - different registers: both take effect.
  - same register: data is written and busy ends at 1 (the new producer wins).
- Reserving an already-busy register leaves it busy. There is no counter and no error flag.
- Writing a non-busy register is legal: the data is written and busy stays 0.
- ZERO_REG=1:
  - address 0 reads 0.
  - writes to 0 are dropped.
  - reserves to 0 are dropped.
  - busy for address 0 is always 0.
  - This holds with or without bypass.
- ZERO_REG=0: register 0 behaves like any other register.
- Both read ports may address the same register, or the write register, in any combination with no conflict.
- Read ports are pure combinational functions of state and addresses. The reserve inputs never affect read data.
- anyBusy = |busy, combinational from state.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: when writeEnable=1 and writeReg equals a read address (non-zero if ZERO_REG=1), that readData returns writeData combinationally in the same cycle, and the matching busy output reads 0 (pending release).
- Undefined: reads return the stored value until the edge, and busy reflects stored state only.

Decomposition:
- Shared package regfile_pkg holds:
  - defaults DATA_W_DEF=16, ADDR_W_DEF=3;
  - localparam NREG;
  - the register-address typedef;
  - the ZERO_ADDR constant.
- One sub-module, regfile_scoreboard: NREG busy flops with reserve/release logic, two busy lookups and anyBusy.
- The data array and read muxing stay in regfile_sb.

Test Plan:
- Reset: hold reset=0 with writeEnable=1, writeReg=3, writeData=16'hBEEF, then release. Read r3 gives 16'h0000; anyBusy=0.
- Write/read latency: write r5=16'h1234 at edge N, with readreg1=5. readData1 shows 16'h1234 after edge N. Before the edge it shows the old value without bypass, and 16'h1234 with REGFILE_BYPASS_EN.
- Zero register: write r0=16'hFFFF and reserve r0, then read r0 on both ports. Both read 16'h0000 and busy1=0.
- Scoreboard: reserve r2 at edge N, so busy2=1 and anyBusy=1 after N. Write r2=16'h00AA at edge N+3. Busy clears after N+3 and data reads 16'h00AA.
- Same-edge conflict: with r4 busy, at one edge write r4=16'h0F0F and reserve r4. r4 reads 16'h0F0F and busy stays 1.
- Async reset mid-flight: with r1 and r6 busy, assert reset between edges. busy and data clear immediately without a clock edge; anyBusy=0.
